// File: rtl/decode_length_sequencer_pkg.sv
// Shared decode definitions for the instruction-length sequencer.
//   MAX_INSN_LEN : longest legal instruction in bytes
//   LEN_W        : default width of lengths, offsets and window byte counts
//   state_e      : sequencer FSM states
package decode_length_sequencer_pkg;

  localparam int unsigned MAX_INSN_LEN = 15;
  localparam int unsigned LEN_W        = 5;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_BYTES,
    ST_FAULT
  } state_e;

endpackage

// File: rtl/decode_length_sequencer_if.sv
// Fetch-window / decode-packet bundle between the fetch buffer, the length
// sequencer and the next decode stage.
//   fetch side : fb_valid, fb_count, per-field byte counts -> sequencer
//                fb_shift, fb_shift_valid                  -> fetch buffer
//   decode side: d_valid, d_length, d_*_off, d_fault       -> decode stage
//                d_ready                                   -> sequencer
// slave  : the sequencer's view
// master : the environment's view (fetch buffer + decode stage)
interface decode_length_sequencer_if #(
  parameter int unsigned LEN_W = decode_length_sequencer_pkg::LEN_W
);
  logic             fb_valid;
  logic [LEN_W-1:0] fb_count;
  logic [2:0]       pre_bytes;
  logic [1:0]       op_bytes;
  logic [1:0]       addressing_bytes;
  logic [3:0]       displacement_bytes;
  logic [2:0]       immediate_bytes;
  logic [LEN_W-1:0] fb_shift;
  logic             fb_shift_valid;
  logic             d_valid;
  logic             d_ready;
  logic [LEN_W-1:0] d_length;
  logic [LEN_W-1:0] d_op_off;
  logic [LEN_W-1:0] d_modrm_off;
  logic [LEN_W-1:0] d_disp_off;
  logic [LEN_W-1:0] d_imm_off;
  logic             d_fault;

  modport slave (
    input  fb_valid, fb_count, pre_bytes, op_bytes, addressing_bytes,
           displacement_bytes, immediate_bytes, d_ready,
    output fb_shift, fb_shift_valid, d_valid, d_length, d_op_off,
           d_modrm_off, d_disp_off, d_imm_off, d_fault
  );

  modport master (
    output fb_valid, fb_count, pre_bytes, op_bytes, addressing_bytes,
           displacement_bytes, immediate_bytes, d_ready,
    input  fb_shift, fb_shift_valid, d_valid, d_length, d_op_off,
           d_modrm_off, d_disp_off, d_imm_off, d_fault
  );

endinterface

// File: rtl/decode_length_sequencer_insn_length_adder.sv
// Combinational length/offset adder: turns the five per-field byte counts
// into the total instruction length and the byte offset of each field.
//   i_pre_bytes, i_op_bytes, i_addressing_bytes,
//   i_displacement_bytes, i_immediate_bytes : field byte counts
//   o_len                                   : total length
//   o_op_off, o_modrm_off, o_disp_off,
//   o_imm_off                               : field offsets in the instruction
// Field maxima sum to 16, so LEN_W >= 5 never overflows.
module insn_length_adder #(
  parameter int unsigned LEN_W = 5
) (
  input  logic [2:0]       i_pre_bytes,
  input  logic [1:0]       i_op_bytes,
  input  logic [1:0]       i_addressing_bytes,
  input  logic [3:0]       i_displacement_bytes,
  input  logic [2:0]       i_immediate_bytes,
  output logic [LEN_W-1:0] o_len,
  output logic [LEN_W-1:0] o_op_off,
  output logic [LEN_W-1:0] o_modrm_off,
  output logic [LEN_W-1:0] o_disp_off,
  output logic [LEN_W-1:0] o_imm_off
);

  // Running prefix sum: each offset is the previous one plus its field.
  always_comb begin
    o_op_off    = LEN_W'(i_pre_bytes);
    o_modrm_off = o_op_off    + LEN_W'(i_op_bytes);
    o_disp_off  = o_modrm_off + LEN_W'(i_addressing_bytes);
    o_imm_off   = o_disp_off  + LEN_W'(i_displacement_bytes);
    o_len       = o_imm_off   + LEN_W'(i_immediate_bytes);
  end

endmodule

// File: rtl/decode_length_sequencer.sv
// Instruction-length decode sequencer. Measures the instruction at the head
// of the fetch window, hands a length/offset packet to the decode stage over
// a valid/ready handshake and tells the fetch buffer how many bytes to retire.
//   clk           : clock, all state on rising edge
//   reset_n       : asynchronous active-low reset
//   flush         : redirect; drops the held packet, clears fault, back to RUN
//   bus (slave)   : fetch window in, fb_shift/fb_shift_valid out,
//                   decode packet out with d_valid/d_ready, d_fault
//   stall         : waiting on window bytes, downstream, or faulted
//   retired_count : packets accepted downstream, wraps
module decode_length_sequencer #(
  parameter int unsigned LEN_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  decode_length_sequencer_if.slave  bus,
  output logic                      stall,
  output logic [CNT_W-1:0]          retired_count
);

  import decode_length_sequencer_pkg::*;

  logic [LEN_W-1:0] w_len;
  logic [LEN_W-1:0] w_op_off;
  logic [LEN_W-1:0] w_modrm_off;
  logic [LEN_W-1:0] w_disp_off;
  logic [LEN_W-1:0] w_imm_off;

  logic w_meas;
  logic w_over;
  logic w_fits;
  logic w_free;
  logic w_capture;

  state_e           r_state;
  logic             r_d_valid;
  logic             r_d_fault;
  logic [LEN_W-1:0] r_d_length;
  logic [LEN_W-1:0] r_d_op_off;
  logic [LEN_W-1:0] r_d_modrm_off;
  logic [LEN_W-1:0] r_d_disp_off;
  logic [LEN_W-1:0] r_d_imm_off;
  logic [CNT_W-1:0] r_retired;

  insn_length_adder #(.LEN_W(LEN_W)) u_adder (
    .i_pre_bytes          (bus.pre_bytes),
    .i_op_bytes           (bus.op_bytes),
    .i_addressing_bytes   (bus.addressing_bytes),
    .i_displacement_bytes (bus.displacement_bytes),
    .i_immediate_bytes    (bus.immediate_bytes),
    .o_len                (w_len),
    .o_op_off             (w_op_off),
    .o_modrm_off          (w_modrm_off),
    .o_disp_off           (w_disp_off),
    .o_imm_off            (w_imm_off)
  );

  assign w_meas = bus.fb_valid && (bus.op_bytes != 2'd0);
  assign w_over = w_len > LEN_W'(MAX_INSN_LEN);
  assign w_fits = w_len <= bus.fb_count;
  // Single-entry output register: free when empty or draining this cycle.
  assign w_free = !r_d_valid || bus.d_ready;

  // reset_n gates the combinational strobes so they read 0 while reset is
  // held, even if the window inputs are still active.
  assign w_capture = reset_n && !flush && (r_state != ST_FAULT) &&
                     w_meas && !w_over && w_fits && w_free;

  assign bus.fb_shift_valid = w_capture;
  assign bus.fb_shift       = w_capture ? w_len : '0;

  assign stall = reset_n &&
                 ((r_state != ST_RUN) || (w_meas && !w_capture && !flush));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_RUN;
      r_d_valid     <= 1'b0;
      r_d_fault     <= 1'b0;
      r_d_length    <= '0;
      r_d_op_off    <= '0;
      r_d_modrm_off <= '0;
      r_d_disp_off  <= '0;
      r_d_imm_off   <= '0;
      r_retired     <= '0;
    end else begin
      if (r_d_valid && bus.d_ready)
        r_retired <= r_retired + 1'b1;

      if (flush) begin
        r_state   <= ST_RUN;
        r_d_valid <= 1'b0;
        r_d_fault <= 1'b0;
      end else begin
        if (w_capture) begin
          r_d_valid     <= 1'b1;
          r_d_length    <= w_len;
          r_d_op_off    <= w_op_off;
          r_d_modrm_off <= w_modrm_off;
          r_d_disp_off  <= w_disp_off;
          r_d_imm_off   <= w_imm_off;
        end else if (bus.d_ready) begin
          r_d_valid <= 1'b0;
        end

        case (r_state)
          ST_FAULT: r_state <= ST_FAULT;
          default: begin
            if (w_meas) begin
              if (w_over) begin
                r_state   <= ST_FAULT;
                r_d_fault <= 1'b1;
              end else if (w_capture) begin
                r_state <= ST_RUN;
              end else if (!w_fits) begin
                r_state <= ST_WAIT_BYTES;
              end
              // fits but output register full: hold current state
            end else begin
              r_state <= ST_RUN;
            end
          end
        endcase
      end
    end
  end

  assign bus.d_valid     = r_d_valid;
  assign bus.d_fault     = r_d_fault;
  assign bus.d_length    = r_d_length;
  assign bus.d_op_off    = r_d_op_off;
  assign bus.d_modrm_off = r_d_modrm_off;
  assign bus.d_disp_off  = r_d_disp_off;
  assign bus.d_imm_off   = r_d_imm_off;
  assign retired_count   = r_retired;

endmodule

// File: tb/tb_decode_length_sequencer.sv
// Randomised scoreboard bench for decode_length_sequencer.
module tb_decode_length_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        stall;
  logic [15:0] retired_count;

  decode_length_sequencer_if #(.LEN_W(5)) bus ();

  decode_length_sequencer #(.LEN_W(5), .CNT_W(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .bus           (bus),
    .stall         (stall),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0] len;
    logic [4:0] op;
    logic [4:0] modrm;
    logic [4:0] disp;
    logic [4:0] imm;
  } pkt_t;

  pkt_t        exp_q[$];
  bit          m_valid, m_fault, m_wait;
  logic [15:0] m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_valid = 0;
    m_fault = 0;
    m_wait  = 0;
    m_cnt   = '0;
  endtask

  task automatic idle_inputs();
    bus.fb_valid = 0; bus.fb_count = '0; bus.pre_bytes = '0; bus.op_bytes = '0;
    bus.addressing_bytes = '0; bus.displacement_bytes = '0;
    bus.immediate_bytes = '0; bus.d_ready = 0; flush = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_d_valid"}, bus.d_valid, 0);
    chk({tag, "_d_fault"}, bus.d_fault, 0);
    chk({tag, "_fields"}, {bus.d_length, bus.d_op_off, bus.d_modrm_off,
                           bus.d_disp_off, bus.d_imm_off}, 0);
    chk({tag, "_fb_shift"}, bus.fb_shift, 0);
    chk({tag, "_fb_shift_valid"}, bus.fb_shift_valid, 0);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_retired"}, retired_count, 0);
  endtask

  // One clock cycle: drive, predict from the field-count rules, check
  // mid-cycle, then advance the model after the edge.
  task automatic cycle(input bit fv, input int cnt, input int pre, input int op,
                       input int addr, input int disp, input int imm,
                       input bit rdy, input bit fl);
    int   len;
    bit   meas, free, cap, exp_stall;
    pkt_t p;
    bus.fb_valid = fv; bus.fb_count = 5'(cnt); bus.pre_bytes = 3'(pre);
    bus.op_bytes = 2'(op); bus.addressing_bytes = 2'(addr);
    bus.displacement_bytes = 4'(disp); bus.immediate_bytes = 3'(imm);
    bus.d_ready = rdy; flush = fl;
    len  = pre + op + addr + disp + imm;
    meas = fv && (op != 0);
    free = !m_valid || rdy;
    cap  = !fl && !m_fault && meas && (len <= 15) && (len <= cnt) && free;
    exp_stall = m_fault || m_wait || (meas && !cap && !fl);
    p.len = 5'(len); p.op = 5'(pre); p.modrm = 5'(pre + op);
    p.disp = 5'(pre + op + addr); p.imm = 5'(pre + op + addr + disp);
    @(negedge clk);
    chk("fb_shift_valid", bus.fb_shift_valid, cap);
    chk("fb_shift", bus.fb_shift, cap ? len : 0);
    chk("stall", stall, exp_stall);
    chk("d_valid", bus.d_valid, m_valid);
    chk("d_fault", bus.d_fault, m_fault);
    chk("retired_count", retired_count, m_cnt);
    @(posedge clk);
    #1;
    if (m_valid && rdy) m_cnt = m_cnt + 16'd1;
    if (fl) begin
      exp_q.delete();
      m_valid = 0; m_fault = 0; m_wait = 0;
    end else begin
      if (!m_fault) begin
        if (meas && len > 15)       m_fault = 1;
        else if (cap)               m_wait  = 0;
        else if (meas && len > cnt) m_wait  = 1;
        else if (!meas)             m_wait  = 0;
      end
      if (cap) begin
        exp_q.push_back(p);
        m_valid = 1;
      end else if (rdy) begin
        m_valid = 0;
      end
    end
  endtask

  function automatic int pick_124();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 1;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  // Monitor: whenever a packet is presented, it must match the oldest
  // expected packet; it is retired from the scoreboard on handshake.
  initial begin
    pkt_t act;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1 && bus.d_valid === 1'b1) begin
        act = {bus.d_length, bus.d_op_off, bus.d_modrm_off, bus.d_disp_off, bus.d_imm_off};
        if (exp_q.size() == 0) begin
          chk("packet_unexpected", 1, 0);
        end else begin
          chk("packet", act, exp_q[0]);
          if (bus.d_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] cnt_start;
    idle_inputs();
    model_reset();
    reset_n = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1;
    @(posedge clk);
    #1;

    // Basic capture: length 7, offsets 1/2/3/7
    cycle(1, 16, 1, 1, 1, 4, 0, 1, 0);
    chk("tp1_d_valid", bus.d_valid, 1);
    chk("tp1_len_offs", {bus.d_length, bus.d_op_off, bus.d_modrm_off, bus.d_disp_off,
                         bus.d_imm_off}, {5'd7, 5'd1, 5'd2, 5'd3, 5'd7});
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Short window for 3 cycles, then full window
    repeat (3) cycle(1, 5, 1, 1, 1, 4, 0, 1, 0);
    cycle(1, 16, 1, 1, 1, 4, 0, 1, 0);
    // Boundary: len == fb_count captures, len == fb_count+1 waits
    cycle(1, 6, 1, 1, 1, 2, 1, 1, 0);
    cycle(1, 5, 1, 1, 1, 2, 1, 1, 0);
    cycle(1, 6, 1, 1, 1, 2, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Over-length instruction faults; sticky until flush
    cycle(1, 16, 4, 2, 2, 4, 4, 1, 0);
    chk("tp3_fault", bus.d_fault, 1);
    cycle(1, 16, 1, 1, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("tp3_fault_cleared", bus.d_fault, 0);

    // Backpressure: held packet stays stable, new insn blocked, then accept+capture
    cycle(1, 16, 0, 1, 1, 0, 2, 0, 0);
    cycle(1, 16, 2, 2, 0, 1, 0, 0, 0);
    cycle(1, 16, 2, 2, 0, 1, 0, 0, 0);
    cnt_start = m_cnt;
    cycle(1, 16, 2, 2, 0, 1, 0, 1, 0);
    chk("tp4_retired_inc", retired_count, cnt_start + 16'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);

    // Flush in a capture cycle
    cycle(1, 16, 0, 1, 0, 0, 0, 0, 0);
    cycle(1, 16, 0, 2, 0, 0, 0, 1, 1);
    chk("tp5_d_valid_after_flush", bus.d_valid, 0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 16), $urandom_range(0, 4),
            $urandom_range(0, 2), $urandom_range(0, 2), pick_124(), pick_124(),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);

    // Counter wrap: exactly 65536 accepts return the counter to its start value
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cnt_start = m_cnt;
    for (int i = 0; i < 65536; i++)
      cycle(1, 16, 0, 1, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0);
    chk("wrap_retired", retired_count, cnt_start);

    // Mid-stream asynchronous reset with active inputs
    cycle(1, 16, 1, 1, 1, 1, 1, 0, 0);
    bus.fb_valid = 1; bus.fb_count = 5'd16; bus.op_bytes = 2'd1; bus.d_ready = 0;
    #2;
    reset_n = 0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    idle_inputs();
    #8;
    reset_n = 1;
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 7) != 0, $urandom_range(0, 16), $urandom_range(0, 4),
            $urandom_range(0, 2), $urandom_range(0, 2), pick_124(), pick_124(),
            $urandom_range(0, 1) != 0, $urandom_range(0, 31) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_length_sequencer.md
# decode_length_sequencer

Sequences instruction-length decode between the fetch byte window and the decode pipeline. Each cycle it combines the per-field byte counts (prefix, opcode, ModRM/SIB addressing, displacement, immediate) into a total length and field offsets. When the window holds the whole instruction, it hands a length/offset packet to the next decode stage with a valid/ready handshake and commands the fetch buffer to retire those bytes. It stalls on short windows, faults on over-length instructions, and recovers on flush.

## Interface
Parameters:
- LEN_W, 5, width of lengths, offsets and the fetch-window byte count
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- flush  in  1  redirect/exception; discards in-flight state
- fb_valid  in  1  window byte 0 is an instruction start
- fb_count  in  LEN_W  valid bytes in window, 0..16
- pre_bytes  in  3  prefix byte count, 0..4
- op_bytes  in  2  opcode byte count; 1 or 2, 0 = not yet decodable
- addressing_bytes  in  2  ModRM+SIB byte count, 0..2
- displacement_bytes  in  4  displacement byte count, 0/1/2/4
- immediate_bytes  in  3  immediate byte count, 0/1/2/4
- fb_shift  out  LEN_W  bytes the fetch buffer retires at next edge
- fb_shift_valid  out  1  retire strobe, combinational
- d_valid  out  1  output packet valid
- d_ready  in  1  downstream accepts packet
- d_length  out  LEN_W  total instruction length
- d_op_off, d_modrm_off, d_disp_off, d_imm_off  out  LEN_W each  byte offsets within instruction
- d_fault  out  1  instruction length >15, sticky until flush
- stall  out  1  waiting on bytes or downstream
- retired_count  out  CNT_W  packets accepted downstream, wraps

## Operation
- len = pre+op+addressing+disp+imm, unsigned, LEN_W bits. Maximum 4+2+2+4+4 = 16, so no overflow.
- Offsets:
  - op_off = pre
  - modrm_off = pre+op
  - disp_off = modrm_off+addressing
  - imm_off = disp_off+disp
- Output register is a single entry. It is "free" when d_valid=0 or (d_valid & d_ready).
- States: RUN, WAIT_BYTES, FAULT.
  - RUN/WAIT_BYTES, when fb_valid & op_bytes≠0 & !flush:
    - len>15: go to FAULT, assert d_fault, no shift.
    - Otherwise, if len≤fb_count and the output register is free: capture the packet, fb_shift=len, fb_shift_valid=1, next state RUN.
    - Otherwise, if len>fb_count: go to WAIT_BYTES. Inputs are re-evaluated every cycle while waiting.
    - Otherwise (output register not free): stay, stall=1.
  - fb_valid=0 or op_bytes=0: no capture, no shift, state RUN.
  - FAULT: no captures or shifts; d_valid drains normally. Exits to RUN only on flush.
- flush: highest priority.
  - Same cycle: fb_shift_valid=0.
  - Next edge: d_valid=0, d_fault=0, state RUN.
  - retired_count is not cleared.
- retired_count increments on each d_valid & d_ready edge and wraps from 2^CNT_W−1 to 0.
- stall=1 in WAIT_BYTES, in FAULT, or when a measurable instruction is blocked by a full output register.

## Timing
- Reset values:
  - all d_* = 0
  - d_valid = 0, d_fault = 0
  - fb_shift = 0, fb_shift_valid = 0
  - stall = 0, retired_count = 0
  - state RUN
- Latency: window presented in cycle N → d_valid in cycle N+1. fb_shift_valid is asserted in cycle N; the fetch buffer shifts at the same edge.
- Throughput: one instruction per cycle when d_ready is held at 1.
- While d_valid=1 & d_ready=0, the packet holds stable.
- Capture and accept in the same cycle are legal: the old packet retires and the new packet loads.
- len==fb_count captures. len==fb_count+1 waits.
- reset_n asserted mid-operation clears all state immediately, independent of clk.

## Structure
- Shared decode package holds:
  - MAX_INSN_LEN=15
  - LEN_W
  - state encodings ST_RUN, ST_WAIT_BYTES, ST_FAULT
- Sub-module insn_length_adder: purely combinational. Computes len and the four offsets from the five field counts.
- The top level holds the FSM, the output register, the handshake logic and the counter.

## Test plan
- pre=1, op=1, addr=1, disp=4, imm=0, fb_count=16, d_ready=1 → same cycle fb_shift=7; next cycle d_valid=1, d_length=7, offsets 1/2/3/7.
- Same fields with fb_count=5 for 3 cycles, then 16 → stall=1 and no shift for 3 cycles; capture when fb_count=16.
- pre=4, op=2, addr=2, disp=4, imm=4 (len 16) → d_fault=1 next cycle, no shifts; flush → d_fault=0, RUN.
- d_ready=0 with packet held, new instruction ready → no shift, stall=1, packet stable; d_ready=1 → accept and capture in the same cycle, retired_count+1.
- flush asserted in the capture cycle → fb_shift_valid=0, d_valid=0 next cycle.
- retired_count preset via 65536 back-to-back accepts → wraps to 0; reset_n pulse mid-stream → all outputs 0 asynchronously.
